// File: rtl/note_player_if.sv
// Note player bus: song-reader controls, timing pulses,
// frequency ROM lookup and waveform-generator outputs.
interface note_player_if;
  logic        play;
  logic        new_note;
  logic [5:0]  note;
  logic [5:0]  duration;
  logic [2:0]  metadata;
  logic        beat;
  logic        sample_ready;
  logic [19:0] step_size;
  logic [5:0]  freq_addr;
  logic [19:0] phase;
  logic [2:0]  metadata_q;
  logic        note_active;
  logic        note_done;

  modport master (
    output play, new_note, note, duration, metadata,
    output beat, sample_ready, step_size,
    input  freq_addr, phase, metadata_q,
    input  note_active, note_done
  );

  modport slave (
    input  play, new_note, note, duration, metadata,
    input  beat, sample_ready, step_size,
    output freq_addr, phase, metadata_q,
    output note_active, note_done
  );
endinterface

// File: rtl/note_player.sv
// Plays one note: ROM step lookup, phase accumulation
// per sample, beat counting up to the note duration.
module note_player (
  input logic          clk,
  input logic          reset,
  note_player_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE, LOOKUP, PLAY, DONE
  } state_t;

  state_t      r_state;
  logic [5:0]  r_note;
  logic [5:0]  r_dur;
  logic [5:0]  r_cnt;
  logic [2:0]  r_meta;
  logic [19:0] r_step;
  logic [19:0] r_phase;
  logic        r_active;
  logic        r_done;

  logic [5:0]  w_cnt_inc;
  logic        w_beat;
  logic        w_smp;
  logic        w_finish;

  assign w_cnt_inc = r_cnt + 6'd1;
  assign w_beat    = bus.beat & bus.play;
  assign w_smp     = bus.sample_ready & bus.play;
  // zero-length notes finish on the first PLAY cycle
  assign w_finish  = (r_state == PLAY) &
                     ((r_dur == 6'd0) |
                      (w_beat & (w_cnt_inc == r_dur)));

  assign bus.freq_addr   = r_note;
  assign bus.phase       = r_phase;
  assign bus.metadata_q  = r_meta;
  assign bus.note_active = r_active;
  assign bus.note_done   = r_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_note   <= '0;
      r_dur    <= '0;
      r_cnt    <= '0;
      r_meta   <= '0;
      r_step   <= '0;
      r_phase  <= '0;
      r_active <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.new_note) begin
        r_note   <= bus.note;
        r_dur    <= bus.duration;
        r_meta   <= bus.metadata;
        r_cnt    <= '0;
        r_phase  <= '0;
        r_active <= 1'b1;
        r_state  <= LOOKUP;
      end else begin
        unique case (r_state)
          IDLE: begin
            r_phase  <= '0;
            r_active <= 1'b0;
          end
          LOOKUP: begin
            r_step  <= (r_note == 6'd0) ?
                       20'd0 : bus.step_size;
            r_state <= PLAY;
          end
          PLAY: begin
            if (w_finish) begin
              r_state  <= DONE;
              r_done   <= 1'b1;
              r_phase  <= '0;
              r_active <= 1'b0;
            end else begin
              if (w_beat) r_cnt <= w_cnt_inc;
              if (w_smp)  r_phase <= r_phase + r_step;
            end
          end
          DONE: begin
            r_phase <= '0;
            r_state <= IDLE;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_note_player.sv
// Scoreboard bench for note_player: directed notes,
// per-cycle expected snapshots checked by a monitor.
module tb_note_player;
  logic clk = 1'b0;
  logic reset = 1'b1;
  note_player_if bus();

  note_player dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [19:0] ph;
    logic [5:0]  fa;
    logic        act;
    logic        dn;
    logic [2:0]  meta;
  } exp_t;

  exp_t  q[$];
  string qn[$];
  int n_pass = 0;
  int n_total = 0;
  int n_done_seen = 0;
  int n_done_exp = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_nx(string nm, logic [19:0] ph,
                           logic [5:0] fa, logic act,
                           logic dn, logic [2:0] meta);
    exp_t e;
    e.cyc = cyc + 1;
    e.ph = ph;
    e.fa = fa;
    e.act = act;
    e.dn = dn;
    e.meta = meta;
    q.push_back(e);
    qn.push_back(nm);
    if (dn) n_done_exp++;
  endtask

  task automatic cy(logic b, logic s, string nm,
                    logic [19:0] ph, logic [5:0] fa,
                    logic act, logic dn, logic [2:0] meta);
    bus.beat = b;
    bus.sample_ready = s;
    expect_nx(nm, ph, fa, act, dn, meta);
    tick();
    bus.beat = 1'b0;
    bus.sample_ready = 1'b0;
  endtask

  task automatic send(string nm, logic [5:0] n,
                      logic [5:0] d, logic [2:0] m);
    bus.new_note = 1'b1;
    bus.note = n;
    bus.duration = d;
    bus.metadata = m;
    expect_nx(nm, 20'h0, n, 1'b1, 1'b0, m);
    tick();
    bus.new_note = 1'b0;
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    string nm;
    if (bus.note_done === 1'b1) n_done_seen++;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      nm = qn.pop_front();
      n_total++;
      if (e.cyc != cyc)
        $display("FAIL %s: check missed, due cycle %0d now %0d",
                 nm, e.cyc, cyc);
      else if ({bus.phase, bus.freq_addr, bus.note_active,
                bus.note_done, bus.metadata_q} !==
               {e.ph, e.fa, e.act, e.dn, e.meta})
        $display({"FAIL %s: got ph=%h fa=%0d act=%b done=%b ",
                  "meta=%0d, want ph=%h fa=%0d act=%b done=%b meta=%0d"},
                 nm, bus.phase, bus.freq_addr, bus.note_active,
                 bus.note_done, bus.metadata_q,
                 e.ph, e.fa, e.act, e.dn, e.meta);
      else
        n_pass++;
    end
  end

  initial begin
    bus.play = 1'b1;
    bus.new_note = 1'b0;
    bus.note = '0;
    bus.duration = '0;
    bus.metadata = '0;
    bus.beat = 1'b0;
    bus.sample_ready = 1'b0;
    bus.step_size = '0;
    reset = 1'b1;
    tick();
    expect_nx("reset", 20'h0, 6'd0, 1'b0, 1'b0, 3'd0);
    tick();
    reset = 1'b0;
    cy(0, 0, "idle0", 20'h0, 6'd0, 1'b0, 1'b0, 3'd0);

    // basic note, 3 beats, step 0x100
    bus.step_size = 20'h00100;
    send("t1 lookup", 6'd10, 6'd3, 3'd5);
    cy(0, 0, "t1 play", 20'h0, 6'd10, 1, 0, 3'd5);
    cy(0, 1, "t1 s1", 20'h100, 6'd10, 1, 0, 3'd5);
    cy(0, 1, "t1 s2", 20'h200, 6'd10, 1, 0, 3'd5);
    cy(1, 0, "t1 b1", 20'h200, 6'd10, 1, 0, 3'd5);
    cy(1, 1, "t1 b2s", 20'h300, 6'd10, 1, 0, 3'd5);
    cy(1, 0, "t1 done", 20'h0, 6'd10, 0, 1, 3'd5);
    cy(0, 0, "t1 idle", 20'h0, 6'd10, 0, 0, 3'd5);

    // pause freezes beat count and phase
    bus.step_size = 20'h00010;
    send("t2 lookup", 6'd7, 6'd2, 3'd3);
    cy(0, 0, "t2 play", 20'h0, 6'd7, 1, 0, 3'd3);
    cy(0, 1, "t2 s1", 20'h10, 6'd7, 1, 0, 3'd3);
    cy(1, 0, "t2 b1", 20'h10, 6'd7, 1, 0, 3'd3);
    bus.play = 1'b0;
    for (int i = 0; i < 5; i++)
      cy(i < 2, 1, "t2 frozen", 20'h10, 6'd7, 1, 0, 3'd3);
    bus.play = 1'b1;
    cy(1, 0, "t2 done", 20'h0, 6'd7, 0, 1, 3'd3);
    cy(0, 0, "t2 idle", 20'h0, 6'd7, 0, 0, 3'd3);

    // preemption during PLAY
    bus.step_size = 20'h00040;
    send("t3 lookup", 6'd12, 6'd5, 3'd1);
    cy(0, 0, "t3 play", 20'h0, 6'd12, 1, 0, 3'd1);
    cy(0, 1, "t3 s1", 20'h40, 6'd12, 1, 0, 3'd1);
    cy(1, 1, "t3 b1s", 20'h80, 6'd12, 1, 0, 3'd1);
    bus.step_size = 20'h00008;
    send("t3 preempt", 6'd20, 6'd1, 3'd6);
    cy(0, 0, "t3 play2", 20'h0, 6'd20, 1, 0, 3'd6);
    cy(0, 1, "t3 s2", 20'h8, 6'd20, 1, 0, 3'd6);
    cy(1, 0, "t3 done", 20'h0, 6'd20, 0, 1, 3'd6);
    cy(0, 0, "t3 idle", 20'h0, 6'd20, 0, 0, 3'd6);

    // rest note forces step 0
    bus.step_size = 20'hABCDE;
    send("t4 lookup", 6'd0, 6'd2, 3'd2);
    cy(0, 0, "t4 play", 20'h0, 6'd0, 1, 0, 3'd2);
    cy(1, 1, "t4 b1s", 20'h0, 6'd0, 1, 0, 3'd2);
    cy(0, 1, "t4 s2", 20'h0, 6'd0, 1, 0, 3'd2);
    cy(1, 0, "t4 done", 20'h0, 6'd0, 0, 1, 3'd2);
    cy(0, 0, "t4 idle", 20'h0, 6'd0, 0, 0, 3'd2);

    // zero duration, new note accepted during DONE
    bus.step_size = 20'h00003;
    send("t5 lookup", 6'd33, 6'd0, 3'd4);
    cy(0, 0, "t5 play", 20'h0, 6'd33, 1, 0, 3'd4);
    cy(0, 0, "t5 done", 20'h0, 6'd33, 0, 1, 3'd4);
    send("t5 relookup", 6'd9, 6'd1, 3'd7);
    cy(0, 0, "t5 play2", 20'h0, 6'd9, 1, 0, 3'd7);
    cy(1, 1, "t5 done2", 20'h0, 6'd9, 0, 1, 3'd7);
    cy(0, 0, "t5 idle", 20'h0, 6'd9, 0, 0, 3'd7);

    // phase wrap, then reset mid-note beats new_note
    bus.step_size = 20'hFFFFF;
    send("t6 lookup", 6'd5, 6'd1, 3'd2);
    cy(0, 0, "t6 play", 20'h0, 6'd5, 1, 0, 3'd2);
    cy(0, 1, "t6 s1", 20'hFFFFF, 6'd5, 1, 0, 3'd2);
    cy(0, 1, "t6 wrap", 20'hFFFFE, 6'd5, 1, 0, 3'd2);
    reset = 1'b1;
    bus.new_note = 1'b1;
    bus.note = 6'd44;
    bus.duration = 6'd1;
    bus.metadata = 3'd3;
    bus.beat = 1'b1;
    expect_nx("t6 reset", 20'h0, 6'd0, 0, 0, 3'd0);
    tick();
    reset = 1'b0;
    bus.new_note = 1'b0;
    bus.beat = 1'b0;
    cy(0, 0, "t6 idle", 20'h0, 6'd0, 0, 0, 3'd0);

    tick();
    tick();
    n_total++;
    if (n_done_seen != n_done_exp)
      $display("FAIL done_count: got %0d, want %0d",
               n_done_seen, n_done_exp);
    else
      n_pass++;
    n_total++;
    if (q.size() != 0)
      $display("FAIL sb_drain: got %0d pending, want 0",
               q.size());
    else
      n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
